mips_muldiv_unit: RTL

//  Iterative multiply/divide unit with HI/LO registers for the MIPS core (MULT, MULTU, DIV, DIVU, MTHI, MTLO).

---
 rtl/mips_muldiv_pkg.sv | 18 +
 rtl/mips_muldiv_step.sv | 30 +++
 rtl/mips_muldiv_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared op codes and FSM encoding for the MIPS multiply/divide unit.
// Imported by the unit top and the bench.
package mips_muldiv_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Accumulator is {upper WIDTH+1 bits, lower WIDTH bits}.
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [WIDTH-1:0]   opnd,
  input  logic [2*WIDTH:0]   acc_in,
  output logic [2*WIDTH:0]   acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    sum    = acc_in[2*WIDTH:WIDTH]
           + (acc_in[0] ? {1'b0, opnd} : '0);
    rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
    ge     = rem_sh >= {1'b0, opnd};
    diff   = rem_sh - {1'b0, opnd};
    if (div)
      acc_out = {(ge ? diff : rem_sh),
                 acc_in[WIDTH-2:0], ge};
    else
      acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in FIXUP.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH+1);

  mdu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz;

  logic               md_op;
  logic               mt_op;
  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    md_op = 1'b0;
    mt_op = 1'b0;
    unique case (1'b1)
      (op <= MDU_DIVU): md_op = 1'b1;
      (op == MDU_MTHI),
      (op == MDU_MTLO): mt_op = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sgn   = md_op & ~op[0];
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div     (is_div),
    .opnd    (opnd),
    .acc_in  (acc),
    .acc_out (acc_next)
  );

  always_comb begin
    prod   = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH]
                     : acc[2*WIDTH-1:WIDTH];
      if (dz) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done       <= 1'b0;
      illegal_op <= 1'b0;
      unique case (state)
        IDLE: if (start && !flush) begin
          div_by_zero <= 1'b0;
          unique case (1'b1)
            md_op: begin
              state  <= CALC;
              busy   <= 1'b1;
              cnt    <= '0;
              is_div <= op[1];
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              dz     <= (b == '0);
              a_raw  <= a;
              // multiplier or dividend sits in the low half
              opnd   <= op[1] ? b_mag : a_mag;
              acc    <= {{(WIDTH+1){1'b0}},
                         (op[1] ? a_mag : b_mag)};
            end
            mt_op: begin
              if (op == MDU_MTHI) hi <= a;
              else                lo <= a;
              done <= 1'b1;
            end
            default: illegal_op <= 1'b1;
          endcase
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH-1)) state <= FIXUP;
          end
        end
        FIXUP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= is_div & dz;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
